// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : Test-pattern generator driven by an external sync generator.
//               Tracks pixel/line position from hactive/next_line/next_frame,
//               renders one of four patterns (colour bars, checkerboard,
//               gradient, moving bar) and presents RGB444 with active-low
//               syncs and data enable, all delayed by two clocks.
// Ports       : clk          - pixel clock
//               rst          - synchronous active-high reset
//               hsync/vsync  - active-high syncs from the timing generator
//               hactive/vactive - active-region flags
//               next_line    - one-cycle pulse at end of each line
//               next_frame   - one-cycle pulse at end of each frame
//               mode[1:0]    - pattern select, taken at frame boundaries
//               vga_r/g/b    - RGB444 pixel
//               vga_hsync_n/vga_vsync_n - active-low syncs aligned to pixels
//               vga_de       - data enable aligned to pixels
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BAR_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hactive,
    input  logic       vactive,
    input  logic       next_line,
    input  logic       next_frame,
    input  logic [1:0] mode,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hsync_n,
    output logic       vga_vsync_n,
    output logic       vga_de
);

    localparam int          c_seg_w     = H_ACTIVE / 8;
    localparam logic [9:0]  c_x_max     = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  c_y_max     = 10'(V_ACTIVE - 1);
    localparam logic [10:0] c_h_active  = 11'(H_ACTIVE);
    localparam logic [10:0] c_bar_step  = 11'(BAR_STEP);
    localparam logic [10:0] c_bar_len   = 11'd16;

    // ------------------------------------------------------------------
    // Position, mode and animation state
    // ------------------------------------------------------------------
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  frame_q, frame_d;
    logic [9:0]  bar_x_q, bar_x_d;
    logic [10:0] w_bar_sum;
    logic [10:0] w_bar_wrap;

    always_comb begin
        x_d = x_q;
        if (next_line) begin
            x_d = '0;
        end else if (hactive && (x_q != c_x_max)) begin
            x_d = x_q + 10'd1;
        end
    end

    always_comb begin
        y_d = y_q;
        if (next_frame) begin
            y_d = '0;
        end else if (next_line && vactive && (y_q != c_y_max)) begin
            y_d = y_q + 10'd1;
        end
    end

    // Bar advance computed one bit wider so the wrap compare cannot overflow.
    always_comb begin
        w_bar_sum  = {1'b0, bar_x_q} + c_bar_step;
        w_bar_wrap = (w_bar_sum >= c_h_active) ? (w_bar_sum - c_h_active) : w_bar_sum;
        bar_x_d    = next_frame ? w_bar_wrap[9:0] : bar_x_q;
        frame_d    = next_frame ? (frame_q + 8'd1) : frame_q;
        mode_d     = next_frame ? mode : mode_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            bar_x_q <= '0;
            mode_q  <= mode;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            bar_x_q <= bar_x_d;
            mode_q  <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: snapshot of the current cycle's position and timing
    // ------------------------------------------------------------------
    logic [9:0] s1_x_q;
    logic [9:0] s1_y_q;
    logic       s1_de_q;
    logic       s1_hs_q;
    logic       s1_vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_x_q  <= '0;
            s1_y_q  <= '0;
            s1_de_q <= 1'b0;
            s1_hs_q <= 1'b0;
            s1_vs_q <= 1'b0;
        end else begin
            s1_x_q  <= x_q;
            s1_y_q  <= y_q;
            s1_de_q <= hactive & vactive;
            s1_hs_q <= hsync;
            s1_vs_q <= vsync;
        end
    end

    // ------------------------------------------------------------------
    // Colour generation from stage-1 values
    // ------------------------------------------------------------------
    logic [2:0]  w_bar_idx;
    logic [10:0] w_bar_end;
    logic        w_in_bar;
    logic [11:0] w_rgb;

    // Colour-bar index = number of segment thresholds the pixel has reached.
    always_comb begin
        w_bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (s1_x_q >= 10'(k * c_seg_w)) begin
                w_bar_idx = w_bar_idx + 3'd1;
            end
        end
    end

    // The bar is not wrapped: its end is evaluated in 11 bits.
    always_comb begin
        w_bar_end = {1'b0, bar_x_q} + c_bar_len;
        w_in_bar  = (s1_x_q >= bar_x_q) && ({1'b0, s1_x_q} < w_bar_end);
    end

    always_comb begin
        w_rgb = 12'h000;
        case (mode_q)
            2'd0: begin
                case (w_bar_idx)
                    3'd0:    w_rgb = 12'hFFF;
                    3'd1:    w_rgb = 12'hFF0;
                    3'd2:    w_rgb = 12'h0FF;
                    3'd3:    w_rgb = 12'h0F0;
                    3'd4:    w_rgb = 12'hF0F;
                    3'd5:    w_rgb = 12'hF00;
                    3'd6:    w_rgb = 12'h00F;
                    default: w_rgb = 12'h000;
                endcase
            end
            2'd1:    w_rgb = (s1_x_q[5] ^ s1_y_q[5]) ? 12'hFFF : 12'h000;
            2'd2:    w_rgb = {s1_x_q[9:6], s1_y_q[8:5], frame_q[3:0]};
            default: w_rgb = w_in_bar ? 12'hFFF : 12'h004;
        endcase
        // Blank outside the active area regardless of pattern.
        if (!s1_de_q) begin
            w_rgb = 12'h000;
        end
    end

    // Bits of state that no pattern looks at.
    logic w_unused;
    assign w_unused = ^{frame_q[7:4], s1_y_q[9], s1_y_q[4:0]};

    // ------------------------------------------------------------------
    // Stage 2: output registers
    // ------------------------------------------------------------------
    logic [11:0] rgb_q;
    logic        de_q;
    logic        hs_q;
    logic        vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            rgb_q <= w_rgb;
            de_q  <= s1_de_q;
            hs_q  <= s1_hs_q;
            vs_q  <= s1_vs_q;
        end
    end

    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_de      = de_q;
    assign vga_hsync_n = ~hs_q;
    assign vga_vsync_n = ~vs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pattern_gen
// Description : Directed self-checking bench for vga_pattern_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int LINE_LEN = H_ACTIVE + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       hsync, vsync, hactive, vactive, next_line, next_frame;
    logic [1:0] mode;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hsync_n, vga_vsync_n, vga_de;

    int checks   = 0;
    int errors   = 0;
    int n_frames = 0;

    logic [11:0] cap_rgb [0:H_ACTIVE-1];
    logic        cap_de  [0:H_ACTIVE-1];
    logic [11:0] bar_exp [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                   12'hF0F, 12'hF00, 12'h00F, 12'h000};

    vga_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BAR_STEP (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .hactive     (hactive),
        .vactive     (vactive),
        .next_line   (next_line),
        .next_frame  (next_frame),
        .mode        (mode),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hsync_n (vga_hsync_n),
        .vga_vsync_n (vga_vsync_n),
        .vga_de      (vga_de)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hsync = 0; vsync = 0; hactive = 0; vactive = 0;
        next_line = 0; next_frame = 0;
    endtask

    task automatic pulse_frame();
        idle_inputs();
        next_line = 1; next_frame = 1;
        step();
        idle_inputs();
        n_frames++;
    endtask

    task automatic advance_line();
        idle_inputs();
        vactive = 1; next_line = 1;
        step();
        idle_inputs();
    endtask

    // One full line; output seen after step i belongs to the pixel driven at step i-1.
    task automatic feed_line(input logic va);
        for (int i = 0; i < LINE_LEN; i++) begin
            hactive   = (i < H_ACTIVE);
            vactive   = va;
            hsync     = (i == H_ACTIVE + 1) || (i == H_ACTIVE + 2);
            next_line = (i == LINE_LEN - 1);
            step();
            if (i >= 1 && i <= H_ACTIVE) begin
                cap_rgb[i-1] = {vga_r, vga_g, vga_b};
                cap_de[i-1]  = vga_de;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1; mode = 2'd0;
        hsync = 1; vsync = 1; hactive = 1; vactive = 1;
        next_line = 0; next_frame = 0;
        step(); step();
        checks++;
        if ({vga_r, vga_g, vga_b, vga_de, vga_hsync_n, vga_vsync_n} !== {12'h000, 3'b011}) begin
            errors++;
            $display("FAIL reset_hold: got rgb=%h de=%b hs_n=%b vs_n=%b, expected rgb=000 de=0 hs_n=1 vs_n=1",
                     {vga_r, vga_g, vga_b}, vga_de, vga_hsync_n, vga_vsync_n);
        end
        rst = 0;
        idle_inputs();
        step();
        checks++;
        if ({vga_r, vga_g, vga_b, vga_de, vga_hsync_n, vga_vsync_n} !== {12'h000, 3'b011}) begin
            errors++;
            $display("FAIL reset_first_cycle: got rgb=%h de=%b hs_n=%b vs_n=%b, expected rgb=000 de=0 hs_n=1 vs_n=1",
                     {vga_r, vga_g, vga_b}, vga_de, vga_hsync_n, vga_vsync_n);
        end
        n_frames = 0;
        step(); step();
    endtask

    task automatic test_latency();
        logic exp_hs [0:2] = '{1'b1, 1'b0, 1'b1};
        idle_inputs();
        hsync = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            hsync = 0;
            checks++;
            if (vga_hsync_n !== exp_hs[i]) begin
                errors++;
                $display("FAIL hsync_latency[%0d]: got %b expected %b", i, vga_hsync_n, exp_hs[i]);
            end
        end
        vsync = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            vsync = 0;
            checks++;
            if (vga_vsync_n !== exp_hs[i]) begin
                errors++;
                $display("FAIL vsync_latency[%0d]: got %b expected %b", i, vga_vsync_n, exp_hs[i]);
            end
        end
        hactive = 1; vactive = 1;
        step();
        checks++;
        if (vga_de !== 1'b0) begin
            errors++;
            $display("FAIL de_latency_early: got %b expected 0", vga_de);
        end
        step();
        checks++;
        if (vga_de !== 1'b1) begin
            errors++;
            $display("FAIL de_latency_rise: got %b expected 1", vga_de);
        end
        idle_inputs();
        advance_line();
        step(); step();
    endtask

    task automatic test_colour_bars();
        mode = 2'd0;
        pulse_frame();
        feed_line(1'b1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap_rgb[k*80] !== bar_exp[k]) begin
                errors++;
                $display("FAIL bars_x%0d: got %h expected %h", k*80, cap_rgb[k*80], bar_exp[k]);
            end
            checks++;
            if (cap_rgb[k*80+79] !== bar_exp[k]) begin
                errors++;
                $display("FAIL bars_x%0d: got %h expected %h", k*80+79, cap_rgb[k*80+79], bar_exp[k]);
            end
        end
        checks++;
        if (cap_de[0] !== 1'b1 || cap_de[639] !== 1'b1) begin
            errors++;
            $display("FAIL bars_de: got %b/%b expected 1/1", cap_de[0], cap_de[639]);
        end
    endtask

    task automatic test_checker();
        mode = 2'd1;
        pulse_frame();
        feed_line(1'b1);
        checks++;
        if (cap_rgb[32] !== 12'hFFF) begin
            errors++;
            $display("FAIL checker_32_0: got %h expected fff", cap_rgb[32]);
        end
        checks++;
        if (cap_rgb[0] !== 12'h000) begin
            errors++;
            $display("FAIL checker_0_0: got %h expected 000", cap_rgb[0]);
        end
        for (int i = 0; i < 31; i++) advance_line();
        feed_line(1'b1);
        checks++;
        if (cap_rgb[32] !== 12'h000) begin
            errors++;
            $display("FAIL checker_32_32: got %h expected 000", cap_rgb[32]);
        end
        checks++;
        if (cap_rgb[0] !== 12'hFFF) begin
            errors++;
            $display("FAIL checker_0_32: got %h expected fff", cap_rgb[0]);
        end
    endtask

    task automatic test_mode_change();
        mode = 2'd0;
        pulse_frame();
        mode = 2'd1;
        feed_line(1'b1);
        checks++;
        if (cap_rgb[0] !== 12'hFFF || cap_rgb[80] !== 12'hFF0) begin
            errors++;
            $display("FAIL mode_hold: got %h/%h expected fff/ff0", cap_rgb[0], cap_rgb[80]);
        end
        pulse_frame();
        feed_line(1'b1);
        checks++;
        if (cap_rgb[0] !== 12'h000 || cap_rgb[32] !== 12'hFFF) begin
            errors++;
            $display("FAIL mode_switch: got %h/%h expected 000/fff", cap_rgb[0], cap_rgb[32]);
        end
    endtask

    task automatic test_gradient();
        logic [3:0] fb;
        mode = 2'd2;
        pulse_frame();
        fb = 4'(n_frames);
        for (int i = 0; i < 96; i++) advance_line();
        feed_line(1'b1);
        checks++;
        if (cap_rgb[448] !== {4'h7, 4'h3, fb}) begin
            errors++;
            $display("FAIL gradient_448_96: got %h expected %h", cap_rgb[448], {4'h7, 4'h3, fb});
        end
        checks++;
        if (cap_rgb[639] !== {4'h9, 4'h3, fb}) begin
            errors++;
            $display("FAIL gradient_639_96: got %h expected %h", cap_rgb[639], {4'h9, 4'h3, fb});
        end
    endtask

    task automatic test_bar_wrap();
        idle_inputs();
        mode = 2'd3;
        rst = 1;
        step(); step();
        rst = 0;
        n_frames = 0;
        for (int i = 0; i < 159; i++) pulse_frame();
        // Bar now at 636: covers 636..639 only, never wrapping to x=0.
        feed_line(1'b1);
        checks++;
        if (cap_rgb[636] !== 12'hFFF || cap_rgb[639] !== 12'hFFF) begin
            errors++;
            $display("FAIL bar_636_edge: got %h/%h expected fff/fff", cap_rgb[636], cap_rgb[639]);
        end
        checks++;
        if (cap_rgb[635] !== 12'h004 || cap_rgb[0] !== 12'h004) begin
            errors++;
            $display("FAIL bar_636_outside: got %h/%h expected 004/004", cap_rgb[635], cap_rgb[0]);
        end
        pulse_frame();
        feed_line(1'b1);
        checks++;
        if (cap_rgb[0] !== 12'hFFF || cap_rgb[15] !== 12'hFFF) begin
            errors++;
            $display("FAIL bar_wrap_in: got %h/%h expected fff/fff", cap_rgb[0], cap_rgb[15]);
        end
        checks++;
        if (cap_rgb[16] !== 12'h004) begin
            errors++;
            $display("FAIL bar_wrap_16: got %h expected 004", cap_rgb[16]);
        end
        // 161st frame: frame counter low nibble is 1.
        mode = 2'd2;
        pulse_frame();
        feed_line(1'b1);
        checks++;
        if (cap_rgb[0] !== 12'h001 || cap_rgb[639] !== 12'h901) begin
            errors++;
            $display("FAIL frame_count_161: got %h/%h expected 001/901", cap_rgb[0], cap_rgb[639]);
        end
    endtask

    task automatic test_reset_midline();
        idle_inputs();
        mode = 2'd0;
        hactive = 1; vactive = 1;
        for (int i = 0; i < 100; i++) step();
        hsync = 1;
        rst = 1;
        step();
        checks++;
        if ({vga_r, vga_g, vga_b, vga_de, vga_hsync_n} !== {12'h000, 2'b01}) begin
            errors++;
            $display("FAIL midline_reset: got rgb=%h de=%b hs_n=%b expected rgb=000 de=0 hs_n=1",
                     {vga_r, vga_g, vga_b}, vga_de, vga_hsync_n);
        end
        rst = 0;
        hsync = 0;
        for (int i = 0; i < 50; i++) step();
        advance_line();
        feed_line(1'b1);
        checks++;
        if (cap_rgb[0] !== 12'hFFF || cap_rgb[79] !== 12'hFFF || cap_rgb[80] !== 12'hFF0 || cap_de[0] !== 1'b1) begin
            errors++;
            $display("FAIL midline_next_line: got %h/%h/%h de=%b expected fff/fff/ff0 de=1",
                     cap_rgb[0], cap_rgb[79], cap_rgb[80], cap_de[0]);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_colour_bars();
        test_checker();
        test_mode_change();
        test_gradient();
        test_bar_wrap();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
